// File: rtl/issue_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// issue_scheduler_pkg
// Shared definitions for the in-order issue scheduler:
//   - instruction field positions (opcode, rd, rs, rt)
//   - opcode constants used by source-operand decode
//   - scheduler FSM state encoding
//   - default bubble (NOP) word
//   - reads_rt(): whether an opcode consumes the rt field as a source
// -----------------------------------------------------------------------------
package issue_scheduler_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;

  localparam logic [5:0] OPC_0  = 6'd0;
  localparam logic [5:0] OPC_1  = 6'd1;
  localparam logic [5:0] OPC_2  = 6'd2;
  localparam logic [5:0] OPC_3  = 6'd3;
  localparam logic [5:0] OPC_4  = 6'd4;
  localparam logic [5:0] OPC_5  = 6'd5;
  localparam logic [5:0] OPC_6  = 6'd6;
  localparam logic [5:0] OPC_7  = 6'd7;
  localparam logic [5:0] OPC_11 = 6'd11;
  localparam logic [5:0] OPC_14 = 6'd14;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } sched_state_e;

  // Only the three-register ALU forms (2..7) read rt. Opcodes 0/1 and the
  // I-type forms reuse bits [15:11] as immediate, so they must not be matched
  // against the scoreboard.
  function automatic logic reads_rt(input logic [5:0] opc);
    logic r;
    case (opc)
      OPC_2, OPC_3, OPC_4, OPC_5, OPC_6, OPC_7: r = 1'b1;
      OPC_0, OPC_1, OPC_11, OPC_14:             r = 1'b0;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/issue_scheduler_fifo.sv
// -----------------------------------------------------------------------------
// sched_fifo
// Synchronous instruction buffer with a synchronous flush. The head entry is
// presented combinationally so the scheduler can decode it in the same cycle.
// Ports:
//   clk, rst (async active-low)
//   push/push_data   write one entry (ignored when full or flushing)
//   pop              drop the head entry (ignored when empty or flushing)
//   flush            discard all entries at the next edge
//   head_data        current head entry (valid when !empty)
//   empty, full      occupancy flags
// -----------------------------------------------------------------------------
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// In-order issue stage: buffers incoming instructions and releases the head to
// the pipeline only when none of its source registers is still being produced
// by an in-flight instruction. A PIPE_LAT-deep scoreboard shift register
// records the destination of every issued instruction.
// Ports:
//   clk                sole clock, rising edge
//   rst                asynchronous active-low reset
//   in_valid/in_ready  upstream handshake for in_instr
//   in_instr           opcode[31:26] rd[25:21] rs[20:16] rt[15:11] imm[15:0]
//   flush              synchronous discard of buffered instructions
//   issue_instr        registered word for the pipeline (NOP_INSTR on bubble)
//   issue_valid        issue_instr is a real instruction
//   busy               buffer non-empty or any scoreboard slot valid
//   stall_cnt          (only with ISSUE_SCHEDULER_STATS_EN) saturating count
//                      of cycles spent in STALL
// Optional feature macro: ISSUE_SCHEDULER_STATS_EN
// -----------------------------------------------------------------------------
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          PIPE_LAT   = 3,
  parameter logic [31:0] NOP_INSTR  = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic [31:0] issue_instr,
  output logic        issue_valid,
`ifdef ISSUE_SCHEDULER_STATS_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        busy
);

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        issue;
  logic [31:0] head;

  // Input side: no push while full (even alongside a pop) or while flushing.
  assign in_ready = !fifo_full && !flush;
  assign push     = in_valid && in_ready;

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_instr),
    .pop       (issue),
    .flush     (flush),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  logic [5:0] head_opc;
  logic [4:0] head_rd;
  logic [4:0] head_rs;
  logic [4:0] head_rt;
  logic       head_reads_rt;

  assign head_opc      = head[OPC_MSB:OPC_LSB];
  assign head_rd       = head[RD_MSB:RD_LSB];
  assign head_rs       = head[RS_MSB:RS_LSB];
  assign head_rt       = head[RT_MSB:RT_LSB];
  assign head_reads_rt = reads_rt(head_opc);

  logic [PIPE_LAT-1:0] sb_valid_q, sb_valid_d;
  logic [4:0]          sb_rd_q [PIPE_LAT];
  logic [4:0]          sb_rd_d [PIPE_LAT];
  logic                hazard;

  // The oldest slot is the producer's final cycle: its result is readable by
  // an instruction issuing on that same edge, so it is not compared. This
  // gives a dependent exactly PIPE_LAT cycles of separation.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      if (sb_valid_q[i] &&
          ((sb_rd_q[i] == head_rs) || (head_reads_rt && (sb_rd_q[i] == head_rt)))) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    sb_valid_d    = '0;
    sb_valid_d[0] = issue;
    sb_rd_d[0]    = issue ? head_rd : 5'd0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_rd_d[i]    = sb_rd_q[i-1];
    end
  end

  sched_state_e state_q, state_d;
  logic [31:0]  issue_instr_q, issue_instr_d;
  logic         issue_valid_q, issue_valid_d;
  logic         head_ok;

  assign head_ok = !fifo_empty && !hazard;

  always_comb begin
    state_d       = state_q;
    issue         = 1'b0;
    issue_instr_d = NOP_INSTR;
    issue_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (head_ok)          state_d = ST_RUN;
        else if (!fifo_empty) state_d = ST_STALL;
      end
      ST_RUN, ST_STALL: begin
        if (fifo_empty)  state_d = ST_IDLE;
        else if (hazard) state_d = ST_STALL;
        else             state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides both the pop and the state decision; the scoreboard
    // still shifts so in-flight results stay honoured.
    if (flush) begin
      state_d = ST_IDLE;
    end else if (head_ok) begin
      issue         = 1'b1;
      issue_instr_d = head;
      issue_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      issue_instr_q <= NOP_INSTR;
      issue_valid_q <= 1'b0;
      sb_valid_q    <= '0;
    end else begin
      state_q       <= state_d;
      issue_instr_q <= issue_instr_d;
      issue_valid_q <= issue_valid_d;
      sb_valid_q    <= sb_valid_d;
    end
  end

  // Destination tags are qualified by sb_valid_q and need no reset.
  always_ff @(posedge clk) begin
    sb_rd_q <= sb_rd_d;
  end

  assign issue_instr = issue_instr_q;
  assign issue_valid = issue_valid_q;
  assign busy        = !fifo_empty || (|sb_valid_q);

`ifdef ISSUE_SCHEDULER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_STALL) stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 16'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        busy;
`ifdef ISSUE_SCHEDULER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  issue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .issue_instr (issue_instr),
    .issue_valid (issue_valid),
`ifdef ISSUE_SCHEDULER_STATS_EN
    .stall_cnt   (stall_cnt),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic         in_valid;
    logic [31:0]  instr;
    logic         flush;
    logic         exp_valid;
    logic [31:0]  exp_instr;
    logic         exp_busy;
    logic         exp_ready;
    logic [1:0]   exp_state;
  } vec_t;

  vec_t vecs[23];

  logic [31:0] chain[7];
  int          issue_edge[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_instr = 32'h0;
    flush    = 1'b0;
    rst      = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // in_valid, instr, flush, exp_valid, exp_instr, exp_busy, exp_ready, exp_state
    vecs[0]  = '{1'b1, 32'h0C611000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[1]  = '{1'b1, 32'h1BE50000, 1'b0, 1'b1, 32'h0C611000, 1'b1, 1'b1, ST_RUN};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1BE50000, 1'b1, 1'b1, ST_RUN};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, ST_IDLE};
    vecs[6]  = '{1'b1, 32'h2C820014, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[7]  = '{1'b1, 32'h18A41800, 1'b0, 1'b1, 32'h2C820014, 1'b1, 1'b1, ST_RUN};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_STALL};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_STALL};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h18A41800, 1'b1, 1'b1, ST_RUN};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, ST_IDLE};
    vecs[14] = '{1'b1, 32'h2C400000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[15] = '{1'b1, 32'h2C611000, 1'b0, 1'b1, 32'h2C400000, 1'b1, 1'b1, ST_RUN};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h2C611000, 1'b1, 1'b1, ST_RUN};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[18] = '{1'b1, 32'h2C010000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_IDLE};
    vecs[19] = '{1'b1, 32'h0CC00000, 1'b0, 1'b1, 32'h2C010000, 1'b1, 1'b1, ST_RUN};
    vecs[20] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_STALL};
    vecs[21] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_STALL};
    vecs[22] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0CC00000, 1'b1, 1'b1, ST_RUN};

    // Dependency chain r4 <- r5 <- r6 ... each word reads the previous rd.
    chain = '{32'h2C820014, 32'h18A41800, 32'h18C50000, 32'h18E60000,
              32'h19070000, 32'h19280000, 32'h19490000};
    issue_edge = '{2, 5, 8, 11, 14, 17, 20};

    // ---------------- reset state ----------------
    rst = 1'b1;
    #1;
    do_reset();
    chk("rst_issue_instr", issue_instr, 32'h0);
    chk("rst_issue_valid", {31'b0, issue_valid}, 32'h0);
    chk("rst_busy",        {31'b0, busy}, 32'h0);
    chk("rst_in_ready",    {31'b0, in_ready}, 32'h1);
`ifdef ISSUE_SCHEDULER_STATS_EN
    chk("rst_stall_cnt",   {16'b0, stall_cnt}, 32'h0);
`endif

    // ---------------- table: independent, RAW, I-type, r0 ----------------
    for (int i = 0; i < 23; i++) begin
      in_valid = vecs[i].in_valid;
      in_instr = vecs[i].instr;
      flush    = vecs[i].flush;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, issue_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_instr", i), issue_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_busy", i),  {31'b0, busy}, {31'b0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_state", i), {30'b0, dut.state_q}, {30'b0, vecs[i].exp_state});
    end
    in_valid = 1'b0;

    // ---------------- full buffer with stalled chain ----------------
    do_reset();
    begin
      int   widx;
      logic pre_rdy;
      logic acc;
      logic exp_acc;
      logic exp_v;
      logic [31:0] exp_w;
      widx = 0;
      for (int e = 1; e <= 22; e++) begin
        if (widx < 7) begin
          in_valid = 1'b1;
          in_instr = chain[widx];
        end else begin
          in_valid = 1'b0;
          in_instr = 32'h0;
        end
        #0;
        pre_rdy = in_ready;
        step();
        acc = in_valid && pre_rdy;
        if (acc) widx++;
        if (e <= 9) begin
          exp_acc = (e <= 6) || (e == 9);
          chk($sformatf("full_accept_e%0d", e), {31'b0, acc}, {31'b0, exp_acc});
        end
        exp_v = 1'b0;
        exp_w = 32'h0;
        for (int k = 0; k < 7; k++) begin
          if (issue_edge[k] == e) begin
            exp_v = 1'b1;
            exp_w = chain[k];
          end
        end
        chk($sformatf("full_valid_e%0d", e), {31'b0, issue_valid}, {31'b0, exp_v});
        chk($sformatf("full_instr_e%0d", e), issue_instr, exp_w);
      end
    end
    in_valid = 1'b0;

    // ---------------- flush with three buffered ----------------
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      in_valid = 1'b1;
      in_instr = chain[e-1];
      step();
    end
`ifdef ISSUE_SCHEDULER_STATS_EN
    chk("flush_stall_cnt_pre", {16'b0, stall_cnt}, 32'd2);
`endif
    in_valid = 1'b1;
    in_instr = chain[5];
    flush    = 1'b1;
    #1;
    chk("flush_in_ready_low", {31'b0, in_ready}, 32'h0);
    step();
    chk("flush_e6_valid", {31'b0, issue_valid}, 32'h0);
    chk("flush_e6_instr", issue_instr, 32'h0);
    chk("flush_e6_busy",  {31'b0, busy}, 32'h1);
    chk("flush_e6_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_in_ready_back", {31'b0, in_ready}, 32'h1);
    step();
    chk("flush_e7_busy",  {31'b0, busy}, 32'h1);
    chk("flush_e7_valid", {31'b0, issue_valid}, 32'h0);
    step();
    chk("flush_e8_busy",  {31'b0, busy}, 32'h0);
    chk("flush_e8_valid", {31'b0, issue_valid}, 32'h0);
    step();
    chk("flush_e9_busy",  {31'b0, busy}, 32'h0);
`ifdef ISSUE_SCHEDULER_STATS_EN
    chk("flush_stall_cnt_post", {16'b0, stall_cnt}, 32'd2);
`endif

    // ---------------- flush beats a ready pop ----------------
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h0C611000;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    chk("flushpop_valid", {31'b0, issue_valid}, 32'h0);
    chk("flushpop_busy",  {31'b0, busy}, 32'h0);
    flush = 1'b0;
    step();
    chk("flushpop_after_valid", {31'b0, issue_valid}, 32'h0);

    // ---------------- asynchronous reset mid-traffic ----------------
    do_reset();
    in_valid = 1'b1;
    in_instr = chain[0];
    step();
    in_instr = chain[1];
    step();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", {31'b0, issue_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rstmid_issue_instr", issue_instr, 32'h0);
    chk("rstmid_issue_valid", {31'b0, issue_valid}, 32'h0);
    chk("rstmid_busy",        {31'b0, busy}, 32'h0);
    chk("rstmid_state",       {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready", {31'b0, in_ready}, 32'h1);
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("rstmid_idle%0d_valid", e), {31'b0, issue_valid}, 32'h0);
      chk($sformatf("rstmid_idle%0d_busy", e),  {31'b0, busy}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
